// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
//
// Staged reset generator that sits right after the reset synchronizer. It takes
// the synchronized active-low system reset, a level-sampled software reset
// request and a level-sampled watchdog request. From these it produces
// per-stage active-low resets that release in a fixed order:
//   stage 0 (clock/IO glue) -> stage 1 (memories) -> stage 2 (CPU core).
// Every reset event keeps all stages asserted for at least STRETCH_CYCLES.
// The cause of the most recent reset event is recorded.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-low reset (from the reset synchronizer)
//   soft_rst_req_i  software reset request, level; only accepted in RUN
//   wdt_rst_i       watchdog reset request, level; restarts the sequence
//   stage_rst_o     per-stage reset, active-low, registered
//   soft_rst_ack_o  one-cycle pulse on the edge a soft request is accepted
//   rst_cause_o     last reset cause: 01 rst_i, 10 soft, 11 watchdog
//   busy_o          high while any stage is still held in reset
//   state_o         current FSM state (debug observation only)
//
// Request handshake: soft_rst_req_i is a level held by the requester until it
// sees soft_rst_ack_o. The request is only sampled in RUN and is never
// latched, so a request raised earlier is simply seen once RUN is reached.
// wdt_rst_i needs no acknowledge; every edge that samples it high restarts
// the sequence. When both requests arrive together, the watchdog wins.
// -----------------------------------------------------------------------------
module reset_seq #(
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4,
  parameter int NUM_STAGES     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  soft_rst_req_i,
  input  logic                  wdt_rst_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  soft_rst_ack_o,
  output logic [1:0]            rst_cause_o,
  output logic                  busy_o,
  output logic [1:0]            state_o
);

  localparam int CNT_W = $clog2(STRETCH_CYCLES + NUM_STAGES * STAGE_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  localparam logic [1:0] CAUSE_POR  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic                  ack_q, ack_d;
  logic [1:0]            cause_q, cause_d;
  logic                  busy_q, busy_d;

  // Edge number (counted from the start of the sequence) at which stage k
  // releases.
  function automatic logic [31:0] rel_edge(input int k);
    return 32'(STRETCH_CYCLES + k * STAGE_GAP);
  endfunction

  // Counter saturates instead of wrapping, so a stuck sequence can never
  // alias back onto an early release edge.
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    ack_d   = 1'b0;
    cause_d = cause_q;
    busy_d  = busy_q;

    if (wdt_rst_i) begin
      // The restart edge is cycle 0, so the next edge counts as cycle 1.
      // A held request lands here every edge and keeps all stages asserted.
      state_d = STRETCH;
      cnt_d   = '0;
      stage_d = '0;
      cause_d = CAUSE_WDT;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (soft_rst_req_i) begin
            state_d = STRETCH;
            cnt_d   = '0;
            stage_d = '0;
            cause_d = CAUSE_SOFT;
            busy_d  = 1'b1;
            ack_d   = 1'b1;
          end
        end
        default: begin
          // HOLD, STRETCH and RELEASE all advance the same sequence. HOLD
          // always has cnt_q == 0, so its exit edge becomes cycle 1.
          cnt_d = cnt_inc;
          for (int k = 0; k < NUM_STAGES; k++) begin
            if (32'(cnt_inc) >= rel_edge(k)) begin
              stage_d[k] = 1'b1;
            end
          end
          busy_d = ~&stage_d;
          if (&stage_d) begin
            state_d = RUN;
          end else if (stage_d[0]) begin
            state_d = RELEASE;
          end else begin
            state_d = STRETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      ack_q   <= 1'b0;
      cause_q <= CAUSE_POR;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      ack_q   <= ack_d;
      cause_q <= cause_d;
      busy_q  <= busy_d;
    end
  end

  assign stage_rst_o    = stage_q;
  assign soft_rst_ack_o = ack_q;
  assign rst_cause_o    = cause_q;
  assign busy_o         = busy_q;
  assign state_o        = state_q;

endmodule
